// File: rtl/sync_deser_pkg.sv
// Shared types and sizing helpers for the sync-pattern payload deserializer.
package sync_deser_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int DEFAULT_PAYLOAD_W   = 8;
    localparam int DEFAULT_FRAME_CNT_W = 8;

    // Bit counter must reach PAYLOAD_W+1 when a parity bit is appended.
    function automatic int cnt_width(input int payload_w);
        return $clog2(payload_w + 2);
    endfunction

endpackage

// File: rtl/sync_payload_deserializer_collector.sv
// Serial-to-parallel shift register with a bit counter; word_o already includes the bit on bit_i.
module serial_shift_collector #(
    parameter int SR_W     = 8,
    parameter int CNT_W    = 4,
    parameter int LAST_IDX = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic            bit_i,
    output logic [SR_W-1:0] word_o,
    output logic            done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_IDX);

    // Only SR_W-1 bits are stored; the final bit is taken straight from bit_i.
    logic [SR_W-2:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign word_o = {sr_q, bit_i};
    assign done_o = shift_i && (cnt_q == LAST);

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d    = '0;
            sr_d[0] = bit_i;
            cnt_d   = CNT_W'(1);
        end else if (shift_i) begin
            sr_d  = word_o[SR_W-2:0];
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sync_payload_deserializer.sv
// Captures the PAYLOAD_W bits following each sync hit and emits them as a parallel word.
// Optional trailing even-parity bit enabled by defining SYNC_DESER_PARITY_EN.
module sync_payload_deserializer
    import sync_deser_pkg::*;
#(
    parameter int PAYLOAD_W   = DEFAULT_PAYLOAD_W,
    parameter int FRAME_CNT_W = DEFAULT_FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a,
    input  logic                   detected,
    output logic [PAYLOAD_W-1:0]   data,
    output logic                   data_valid,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   parity_err
);

`ifdef SYNC_DESER_PARITY_EN
    localparam int FRAME_BITS = PAYLOAD_W + 1;
`else
    localparam int FRAME_BITS = PAYLOAD_W;
`endif
    localparam int CNT_W = cnt_width(PAYLOAD_W);

    state_e                 state_q, state_d;
    logic                   load, shift, frame_done;
    logic [FRAME_BITS-1:0]  word;
    logic [PAYLOAD_W-1:0]   payload_word;
    logic                   parity_bad;

    logic [PAYLOAD_W-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   perr_q, perr_d;

    serial_shift_collector #(
        .SR_W    (FRAME_BITS),
        .CNT_W   (CNT_W),
        .LAST_IDX(FRAME_BITS - 1)
    ) u_collector (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .shift_i(shift),
        .bit_i  (a),
        .word_o (word),
        .done_o (frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // detected is deliberately ignored in COLLECT: payloads may contain the sync pattern.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (detected)   state_d = COLLECT;
            COLLECT: if (frame_done) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        load  = (state_q == HUNT) && detected;
        shift = (state_q == COLLECT);
    end

`ifdef SYNC_DESER_PARITY_EN
    assign payload_word = word[FRAME_BITS-1:1];
    assign parity_bad   = ^word;
`else
    assign payload_word = word;
    assign parity_bad   = 1'b0;
`endif

    always_comb begin
        data_d  = data_q;
        valid_d = frame_done;
        fcnt_d  = fcnt_q;
        perr_d  = 1'b0;
        if (frame_done) begin
            data_d = payload_word;
            perr_d = parity_bad;
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            perr_q  <= perr_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_cnt  = fcnt_q;
    assign parity_err = perr_q;
    assign busy       = (state_q == COLLECT);

endmodule
